countdown_timer_ctrl: RTL and testbench



---
 rtl/countdown_timer_ctrl.sv | 122 ++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer: prescaled count-down from a loaded value with
// pause/resume, synchronous clear and registered status pulses.
module countdown_timer_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             tick,
  output logic             done
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_TERM = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    // The completion pulse follows the DONE cycle, so it never meets the last tick.
    done_d  = (state_q == S_DONE);
    if (clear) begin
      state_d = S_IDLE;
      pre_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          pre_d = '0;
          if (start) begin
            if (load_val != '0) begin
              state_d = S_RUN;
              cnt_d   = load_val;
            end else begin
              state_d = S_DONE;
              cnt_d   = '0;
            end
          end
        end
        (state_q == S_RUN): begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (pre_q == PRE_TERM) begin
            pre_d  = '0;
            tick_d = 1'b1;
            cnt_d  = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
              state_d = S_DONE;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        (state_q == S_PAUSE): begin
          if (start) begin
            state_d = S_RUN;
          end
        end
        (state_q == S_DONE): begin
          state_d = S_IDLE;
          pre_d   = '0;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          pre_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d   = (state_d == S_RUN) || (state_d == S_PAUSE);
    paused_d = (state_d == S_PAUSE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  assign count  = cnt_q;
  assign busy   = busy_q;
  assign paused = paused_q;
  assign tick   = tick_q;
  assign done   = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: directed scenarios plus random
// traffic checked against a run-cycle arithmetic reference model.
module tb_countdown_timer_ctrl;

  localparam int TD = 4;
  localparam int CW = 8;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_FIN   = 3;

  logic          clk;
  logic          reset;
  logic          start;
  logic          pause;
  logic          clear;
  logic [CW-1:0] load_val;
  logic [CW-1:0] count;
  logic          busy;
  logic          paused;
  logic          tick;
  logic          done;

  int errors = 0;
  int checks = 0;

  int m_phase;
  int m_n;
  int m_rc;
  int e_count;
  int e_busy;
  int e_paused;
  int e_tick;
  int e_done;

  countdown_timer_ctrl #(
    .TICK_DIV(TD),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .clear(clear),
    .load_val(load_val),
    .count(count),
    .busy(busy),
    .paused(paused),
    .tick(tick),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = M_IDLE;
    m_n      = 0;
    m_rc     = 0;
    e_count  = 0;
    e_busy   = 0;
    e_paused = 0;
    e_tick   = 0;
    e_done   = 0;
  endtask

  // Remaining count is derived from completed RUN cycles, not a prescaler.
  task automatic model_step(bit s, bit p, bit c, int lv);
    bit was_fin;
    was_fin = (m_phase == M_FIN);
    e_tick  = 0;
    e_done  = was_fin ? 1 : 0;
    if (c) begin
      m_phase = M_IDLE;
      m_n     = 0;
      m_rc    = 0;
    end else begin
      case (m_phase)
        M_IDLE: begin
          if (s) begin
            m_n     = lv;
            m_rc    = 0;
            m_phase = (lv != 0) ? M_RUN : M_FIN;
          end
        end
        M_RUN: begin
          if (p) begin
            m_phase = M_PAUSE;
          end else begin
            m_rc++;
            if (m_rc % TD == 0) e_tick = 1;
            if (m_rc == m_n * TD) m_phase = M_FIN;
          end
        end
        M_PAUSE: begin
          if (s) m_phase = M_RUN;
        end
        default: m_phase = M_IDLE;
      endcase
    end
    e_count  = (m_phase == M_IDLE) ? 0 : m_n - m_rc / TD;
    e_busy   = (m_phase == M_RUN || m_phase == M_PAUSE) ? 1 : 0;
    e_paused = (m_phase == M_PAUSE) ? 1 : 0;
  endtask

  task automatic check_all();
    chk("count", int'(count), e_count);
    chk("busy", int'(busy), e_busy);
    chk("paused", int'(paused), e_paused);
    chk("tick", int'(tick), e_tick);
    chk("done", int'(done), e_done);
    chk("tick_done_excl", int'(tick & done), 0);
  endtask

  task automatic step(bit s, bit p, bit c, int lv);
    start    = s;
    pause    = p;
    clear    = c;
    load_val = CW'(lv);
    @(posedge clk);
    model_step(s, p, c, lv);
    @(negedge clk);
    check_all();
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_paused", int'(paused), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_done", int'(done), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    clear    = 1'b0;
    load_val = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("init_count", int'(count), 0);
    chk("init_busy", int'(busy), 0);
    chk("init_done", int'(done), 0);
    reset = 1'b1;

    // Load 3: ticks 4, 8, 12 cycles into RUN, done one cycle later.
    step(1'b1, 1'b0, 1'b0, 3);
    chk("l3_busy", int'(busy), 1);
    for (int k = 1; k <= 13; k++) begin
      idle();
      if (k == 4) chk("l3_tick4", int'(tick), 1);
      if (k == 4) chk("l3_cnt4", int'(count), 2);
      if (k == 8) chk("l3_cnt8", int'(count), 1);
      if (k == 12) chk("l3_tick12", int'(tick), 1);
      if (k == 13) chk("l3_done13", int'(done), 1);
    end
    idle();

    // Load 0: straight to completion without ticking.
    step(1'b1, 1'b0, 1'b0, 0);
    chk("l0_busy", int'(busy), 0);
    idle();
    chk("l0_done", int'(done), 1);
    idle();

    // Pause two cycles into the run, hold, then resume.
    step(1'b1, 1'b0, 1'b0, 5);
    idle();
    idle();
    step(1'b0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      chk("ps_cnt", int'(count), 5);
      chk("ps_paused", int'(paused), 1);
    end
    step(1'b1, 1'b0, 1'b0, 0);
    idle();
    chk("ps_notick", int'(tick), 0);
    idle();
    chk("ps_tick", int'(tick), 1);
    for (int k = 0; k < 20; k++) idle();

    // Clear mid-run, then a one-step run.
    step(1'b1, 1'b0, 1'b0, 3);
    for (int k = 0; k < 4; k++) idle();
    chk("clr_pre_cnt", int'(count), 2);
    step(1'b0, 1'b0, 1'b1, 0);
    chk("clr_cnt", int'(count), 0);
    chk("clr_busy", int'(busy), 0);
    idle();
    chk("clr_nodone", int'(done), 0);
    step(1'b1, 1'b0, 1'b0, 1);
    for (int k = 1; k <= 5; k++) begin
      idle();
      if (k == 5) chk("l1_done5", int'(done), 1);
    end

    // Pause and start together at the prescaler terminal.
    step(1'b1, 1'b0, 1'b0, 2);
    for (int k = 0; k < 3; k++) idle();
    step(1'b1, 1'b1, 1'b0, 0);
    chk("ps_term_tick", int'(tick), 0);
    chk("ps_term_paused", int'(paused), 1);
    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b1, 7);
    chk("clr_start_busy", int'(busy), 0);
    idle();

    // Asynchronous reset in the middle of a run.
    step(1'b1, 1'b0, 1'b0, 5);
    for (int k = 0; k < 4; k++) idle();
    chk("rr_pre_cnt", int'(count), 4);
    pulse_reset();
    idle();
    chk("rr_nodone", int'(done), 0);
    step(1'b1, 1'b0, 1'b0, 2);
    chk("rr_restart", int'(busy), 1);
    for (int k = 0; k < 10; k++) idle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit s;
      bit p;
      bit c;
      s = ($urandom_range(0, 99) < 15);
      p = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 39) == 0);
      step(s, p, c, int'($urandom_range(0, 5)));
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
